// File: rtl/memory_stage.sv
// MIPS32 Memory stage: M pipeline register, word load/store over a valid/ready
// data-memory port, W register and optional forwarding (MEM_STAGE_FWD_EN).
module memory_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_out_e,
  input  logic [31:0]       write_data_e,
  input  logic [4:0]        write_reg_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mem_write_e,
  output logic              stall_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              reg_write_w,
  output logic [4:0]        write_reg_w,
  output logic [31:0]       result_w,
  output logic              err_align_w,
  output logic              fwd_valid_m,
  output logic [4:0]        fwd_reg_m,
  output logic [31:0]       fwd_data_m
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_alu_out_m, r_write_data_m;
  logic [4:0]  r_write_reg_m;
  logic        r_reg_write_m, r_mem_to_reg_m, r_mem_write_m;
  logic        w_mem_op_m, w_misalign_m, w_stall, w_req, w_we;
  logic        w_e_access;

  // an E-stage op that will need the memory port once captured
  assign w_e_access   = (mem_to_reg_e | mem_write_e) & (alu_out_e[1:0] == 2'b00);
  assign w_mem_op_m   = r_mem_to_reg_m | r_mem_write_m;
  assign w_misalign_m = w_mem_op_m & (r_alu_out_m[1:0] != 2'b00);
  assign w_stall      = (r_state == S_ACCESS) & ~dmem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_out_m    <= '0;
      r_write_data_m <= '0;
      r_write_reg_m  <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
    end else if (!w_stall) begin
      r_alu_out_m    <= alu_out_e;
      r_write_data_m <= write_data_e;
      r_write_reg_m  <= write_reg_e;
      r_reg_write_m  <= reg_write_e;
      r_mem_to_reg_m <= mem_to_reg_e;
      r_mem_write_m  <= mem_write_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_e_access) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_req = 1'b1;
        w_we  = r_mem_write_m;
        if (dmem_ready) w_state_nxt = w_e_access ? S_ACCESS : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // a stalled edge pushes a bubble so the waiting op reaches W exactly once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_w <= 1'b0;
      write_reg_w <= '0;
      result_w    <= '0;
      err_align_w <= 1'b0;
    end else if (w_stall) begin
      reg_write_w <= 1'b0;
      err_align_w <= 1'b0;
    end else begin
      reg_write_w <= r_reg_write_m & ~(w_misalign_m & r_mem_to_reg_m);
      write_reg_w <= r_write_reg_m;
      result_w    <= r_mem_to_reg_m ? dmem_rdata : r_alu_out_m;
      err_align_w <= w_misalign_m;
    end
  end

  assign stall_m    = w_stall;
  assign dmem_req   = w_req;
  assign dmem_we    = w_we;
  assign dmem_addr  = r_alu_out_m;
  assign dmem_wdata = r_write_data_m;

`ifdef MEM_STAGE_FWD_EN
  assign fwd_valid_m = r_reg_write_m & ~r_mem_to_reg_m;
  assign fwd_reg_m   = r_write_reg_m;
  assign fwd_data_m  = r_alu_out_m;
`else
  assign fwd_valid_m = 1'b0;
  assign fwd_reg_m   = '0;
  assign fwd_data_m  = '0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: op-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_out_e = '0, write_data_e = '0;
  logic [4:0]  write_reg_e = '0;
  logic        reg_write_e = 1'b0, mem_to_reg_e = 1'b0, mem_write_e = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_m, dmem_req, dmem_we, reg_write_w, err_align_w, fwd_valid_m;
  logic [31:0] dmem_addr, dmem_wdata, result_w, fwd_data_m;
  logic [4:0]  write_reg_w, fwd_reg_m;

  int total = 0;
  int bad   = 0;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .stall_m(stall_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .result_w(result_w),
    .err_align_w(err_align_w),
    .fwd_valid_m(fwd_valid_m), .fwd_reg_m(fwd_reg_m), .fwd_data_m(fwd_data_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the op sitting in M and the result last handed to W.
  // An aligned memory op in M owns the port until the memory says ready.
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, ld, st;
  } op_t;

  op_t         m_op;
  logic        mw_rw, mw_err;
  logic [4:0]  mw_wr;
  logic [31:0] mw_res;

  function automatic logic is_mem(input op_t o);
    return o.ld | o.st;
  endfunction
  function automatic logic is_bad(input op_t o);
    return is_mem(o) && (o.alu % 4 != 0);
  endfunction
  function automatic logic m_req();
    return is_mem(m_op) && !is_bad(m_op);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_op = '0; mw_rw = 0; mw_wr = 0; mw_res = 0; mw_err = 0;
    end else if (m_req() && !dmem_ready) begin
      mw_rw  = 0;
      mw_err = 0;
    end else begin
      mw_rw  = m_op.rw && !(is_bad(m_op) && m_op.ld);
      mw_wr  = m_op.wr;
      mw_res = m_op.ld ? dmem_rdata : m_op.alu;
      mw_err = is_bad(m_op);
      m_op   = '{alu_out_e, write_data_e, write_reg_e, reg_write_e, mem_to_reg_e, mem_write_e};
    end
  end

  always @(negedge clk) begin
    logic req;
    req = rst && m_req();
    chk("stall_m",     32'(stall_m),     32'(req && !dmem_ready));
    chk("dmem_req",    32'(dmem_req),    32'(req));
    chk("dmem_we",     32'(dmem_we),     32'(req && m_op.st));
    chk("dmem_addr",   dmem_addr,        m_op.alu);
    chk("dmem_wdata",  dmem_wdata,       m_op.wd);
    chk("reg_write_w", 32'(reg_write_w), 32'(mw_rw));
    chk("write_reg_w", 32'(write_reg_w), 32'(mw_wr));
    chk("result_w",    result_w,         mw_res);
    chk("err_align_w", 32'(err_align_w), 32'(mw_err));
`ifdef MEM_STAGE_FWD_EN
    chk("fwd_valid_m", 32'(fwd_valid_m), 32'(m_op.rw && !m_op.ld));
    chk("fwd_reg_m",   32'(fwd_reg_m),   32'(m_op.wr));
    chk("fwd_data_m",  fwd_data_m,       m_op.alu);
`else
    chk("fwd_valid_m", 32'(fwd_valid_m), 32'd0);
    chk("fwd_reg_m",   32'(fwd_reg_m),   32'd0);
    chk("fwd_data_m",  fwd_data_m,       32'd0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic rw, input logic ld, input logic st);
    alu_out_e = a; write_data_e = d; write_reg_e = r;
    reg_write_e = rw; mem_to_reg_e = ld; mem_write_e = st;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  op_t    mix [12];
  logic   mix_rdy [12];
  int     stalls;

  initial begin
    mix[0]  = '{32'h0000_0500, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0}; mix_rdy[0]  = 1;
    mix[1]  = '{32'h0000_0504, 32'hA5A5_0001, 5'd0, 1'b0, 1'b0, 1'b1}; mix_rdy[1]  = 0;
    mix[2]  = '{32'h0000_0077, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0}; mix_rdy[2]  = 1;
    mix[3]  = '{32'h0000_0509, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1}; mix_rdy[3]  = 0;
    mix[4]  = '{32'h0000_050C, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0}; mix_rdy[4]  = 0;
    mix[5]  = '{32'h0000_0510, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0}; mix_rdy[5]  = 1;
    mix[6]  = '{32'h0000_0514, 32'hBEEF_0006, 5'd0, 1'b0, 1'b0, 1'b1}; mix_rdy[6]  = 1;
    mix[7]  = '{32'h0000_0081, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0}; mix_rdy[7]  = 0;
    mix[8]  = '{32'h0000_0523, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0}; mix_rdy[8]  = 1;
    mix[9]  = '{32'h0000_0528, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0}; mix_rdy[9]  = 0;
    mix[10] = '{32'h0000_0099, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0}; mix_rdy[10] = 1;
    mix[11] = '{32'h0000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0}; mix_rdy[11] = 1;

    // reset: every output low
    tick();
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_res", result_w, 32'd0);
    tick();
    rst = 1'b1;

    // ALU op
    drive(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    @(negedge clk);
`ifdef MEM_STAGE_FWD_EN
    chk("alu_fwd_valid", 32'(fwd_valid_m), 32'd1);
    chk("alu_fwd_data",  fwd_data_m, 32'h1234);
`else
    chk("alu_fwd_off",   32'(fwd_valid_m), 32'd0);
`endif
    tick();
    @(negedge clk);
    chk("alu_rw",  32'(reg_write_w), 32'd1);
    chk("alu_wr",  32'(write_reg_w), 32'd5);
    chk("alu_res", result_w, 32'h1234);

    // load, ready high
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    drive(32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    @(negedge clk);
    chk("ld_req",   32'(dmem_req), 32'd1);
    chk("ld_we",    32'(dmem_we), 32'd0);
    chk("ld_stall", 32'(stall_m), 32'd0);
    tick();
    @(negedge clk);
    chk("ld_req_off", 32'(dmem_req), 32'd0);
    chk("ld_res",     result_w, 32'hCAFE_BABE);
    chk("ld_rw",      32'(reg_write_w), 32'd1);
    chk("ld_wr",      32'(write_reg_w), 32'd8);

    // store, three wait cycles
    dmem_ready = 1'b0;
    drive(32'h200, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    nop();
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stall_m) stalls++;
      chk("st_addr",  dmem_addr, 32'h200);
      chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
      chk("st_rw",    32'(reg_write_w), 32'd0);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    if (stall_m) stalls++;
    chk("st_we",     32'(dmem_we), 32'd1);
    chk("st_stalls", 32'(stalls), 32'd3);
    tick();
    @(negedge clk);
    chk("st_done_req", 32'(dmem_req), 32'd0);
    chk("st_done_rw",  32'(reg_write_w), 32'd0);

    // misaligned load
    dmem_ready = 1'b0;
    drive(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    @(negedge clk);
    chk("mis_req",   32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall_m), 32'd0);
    tick();
    @(negedge clk);
    chk("mis_err", 32'(err_align_w), 32'd1);
    chk("mis_rw",  32'(reg_write_w), 32'd0);
    tick();
    @(negedge clk);
    chk("mis_err_pulse", 32'(err_align_w), 32'd0);

    // back-to-back load then store
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222;
    drive(32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h304, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_req0", 32'(dmem_req), 32'd1);
    chk("b2b_we0",  32'(dmem_we), 32'd0);
    tick();
    nop();
    @(negedge clk);
    chk("b2b_req1",   32'(dmem_req), 32'd1);
    chk("b2b_we1",    32'(dmem_we), 32'd1);
    chk("b2b_stall",  32'(stall_m), 32'd0);
    chk("b2b_ld_res", result_w, 32'h1111_2222);
    tick();

    // reset in the middle of a stalled load
    dmem_ready = 1'b0;
    drive(32'h400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    @(negedge clk);
    chk("rma_req_before", 32'(dmem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rma_req",   32'(dmem_req), 32'd0);
    chk("rma_stall", 32'(stall_m), 32'd0);
    chk("rma_addr",  dmem_addr, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rma_idle", 32'(dmem_req), 32'd0);

    // mixed stream with irregular ready, checked by the model only
    for (int i = 0; i < 12; i++) begin
      drive(mix[i].alu, mix[i].wd, mix[i].wr, mix[i].rw, mix[i].ld, mix[i].st);
      dmem_ready = mix_rdy[i];
      dmem_rdata = 32'h7000_0000 + 32'(i);
      tick();
    end
    nop();
    dmem_ready = 1'b1;
    repeat (4) tick();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
